// File: rtl/hd44780_writer.sv
// HD44780 8-bit write sequencer: takes one byte per valid/ready handshake and produces
// rs/e/data bus timing, including power-up delay and instruction-execution wait.
module hd44780_writer #(
    parameter int PWRUP_CYC     = 4000000,
    parameter int SETUP_CYC     = 4,
    parameter int E_HIGH_CYC    = 25,
    parameter int HOLD_CYC      = 2,
    parameter int EXEC_CYC      = 3700,
    parameter int LONG_EXEC_CYC = 153000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_valid,
    input  logic       wr_rs,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic       busy,
    output logic       lcd_rs,
    output logic       lcd_e,
    output logic [7:0] lcd_data
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_CYC = max2(max2(max2(PWRUP_CYC, SETUP_CYC), max2(E_HIGH_CYC, HOLD_CYC)),
                                  max2(EXEC_CYC, LONG_EXEC_CYC));
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] PWRUP_LD  = CNT_W'(PWRUP_CYC);
    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC);
    localparam logic [CNT_W-1:0] E_HIGH_LD = CNT_W'(E_HIGH_CYC);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC);
    localparam logic [CNT_W-1:0] EXEC_LD   = CNT_W'(EXEC_CYC);
    localparam logic [CNT_W-1:0] LONG_LD   = CNT_W'(LONG_EXEC_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        PWRUP,
        IDLE,
        SETUP,
        E_HIGH,
        HOLD,
        EXEC
    } state_t;

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt, next_cnt;
    logic             accept;
    logic             long_op;

    // Each timed state is loaded with its length on entry and leaves on the edge where cnt is 1.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        accept     = (state == IDLE) && wr_valid && wr_ready;
        long_op    = !lcd_rs && (lcd_data[7:2] == 6'b000000) && (lcd_data[1:0] != 2'b00);

        if (state == IDLE) begin
            if (accept) begin
                next_state = SETUP;
                next_cnt   = SETUP_LD;
            end
        end else if (cnt != CNT_ONE) begin
            next_cnt = cnt - CNT_ONE;
        end else begin
            case (state)
                PWRUP: next_state = IDLE;
                SETUP: begin
                    next_state = E_HIGH;
                    next_cnt   = E_HIGH_LD;
                end
                E_HIGH: begin
                    next_state = HOLD;
                    next_cnt   = HOLD_LD;
                end
                HOLD: begin
                    next_state = EXEC;
                    next_cnt   = long_op ? LONG_LD : EXEC_LD;
                end
                EXEC:    next_state = IDLE;
                default: begin
                    next_state = PWRUP;
                    next_cnt   = PWRUP_LD;
                end
            endcase
        end
    end

    // Outputs are registered from next_state so lcd_e and wr_ready come straight off flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= PWRUP;
            cnt      <= PWRUP_LD;
            lcd_e    <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_data <= 8'h00;
            wr_ready <= 1'b0;
            busy     <= 1'b1;
        end else begin
            state    <= next_state;
            cnt      <= next_cnt;
            lcd_e    <= (next_state == E_HIGH);
            wr_ready <= (next_state == IDLE);
            busy     <= (next_state != IDLE);
            if (accept) begin
                lcd_rs   <= wr_rs;
                lcd_data <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_hd44780_writer.sv
// Scoreboard bench for hd44780_writer: the driver queues each accepted byte and a cycle-based
// timing model checks e, ready, busy and bus contents on every cycle.
module tb_hd44780_writer;

    localparam int PWRUP  = 10;
    localparam int SETUP  = 2;
    localparam int E_HIGH = 3;
    localparam int HOLD   = 1;
    localparam int EXEC   = 5;
    localparam int LONG   = 20;

    logic       clk;
    logic       rst;
    logic       wr_valid;
    logic       wr_rs;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       busy;
    logic       lcd_rs;
    logic       lcd_e;
    logic [7:0] lcd_data;

    hd44780_writer #(
        .PWRUP_CYC    (PWRUP),
        .SETUP_CYC    (SETUP),
        .E_HIGH_CYC   (E_HIGH),
        .HOLD_CYC     (HOLD),
        .EXEC_CYC     (EXEC),
        .LONG_EXEC_CYC(LONG)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_valid(wr_valid),
        .wr_rs   (wr_rs),
        .wr_data (wr_data),
        .wr_ready(wr_ready),
        .busy    (busy),
        .lcd_rs  (lcd_rs),
        .lcd_e   (lcd_e),
        .lcd_data(lcd_data)
    );

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         acc;
    } wr_t;

    wr_t        exp_q[$];
    int         cyc = 0;
    bit         rst_edge = 0;
    int         checks = 0;
    int         errors = 0;
    int         n_accepts = 0;
    int         n_popped = 0;

    bit         in_flight = 0;
    int         acc_edge = 0;
    int         ready_due = 0;
    logic       cur_rs = 1'b0;
    logic [7:0] cur_data = 8'h00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        rst_edge = rst;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
        end
    endtask

    // The model knows only the schedule: e high SETUP..SETUP+E_HIGH-1 edges after accept,
    // ready again after the whole sequence, and bus contents frozen at the accepted byte.
    always @(negedge clk) begin
        wr_t  w;
        bit   exp_e;
        bit   exp_ready;
        bit   is_long;
        if (rst_edge) begin
            exp_q.delete();
            in_flight = 0;
            cur_rs    = 1'b0;
            cur_data  = 8'h00;
            ready_due = cyc + PWRUP;
            checkOutput("rst_e", 32'(lcd_e), 32'd0);
            checkOutput("rst_data", 32'(lcd_data), 32'd0);
            checkOutput("rst_rs", 32'(lcd_rs), 32'd0);
            checkOutput("rst_ready", 32'(wr_ready), 32'd0);
            checkOutput("rst_busy", 32'(busy), 32'd1);
        end else begin
            if (in_flight && cyc >= ready_due) in_flight = 0;
            if (exp_q.size() != 0 && exp_q[0].acc == cyc) begin
                w = exp_q.pop_front();
                n_popped++;
                in_flight = 1;
                acc_edge  = cyc;
                cur_rs    = w.rs;
                cur_data  = w.data;
                is_long   = (w.rs == 1'b0) && (w.data inside {8'h01, 8'h02, 8'h03});
                ready_due = cyc + SETUP + E_HIGH + HOLD + (is_long ? LONG : EXEC);
            end
            exp_e     = in_flight && (cyc >= acc_edge + SETUP) && (cyc < acc_edge + SETUP + E_HIGH);
            exp_ready = !in_flight && (cyc >= ready_due);
            checkOutput("lcd_e", 32'(lcd_e), 32'(exp_e));
            checkOutput("wr_ready", 32'(wr_ready), 32'(exp_ready));
            checkOutput("busy", 32'(busy), 32'(!exp_ready));
            checkOutput("lcd_rs", 32'(lcd_rs), 32'(cur_rs));
            checkOutput("lcd_data", 32'(lcd_data), 32'(cur_data));
        end
    end

    // With scramble set, inputs carry random junk while the block is not ready.
    task automatic applyStimulus(input logic rs, input logic [7:0] data, input bit scramble);
        bit  done;
        int  waited;
        wr_t w;
        done   = 0;
        waited = 0;
        while (!done) begin
            @(negedge clk);
            if (wr_ready && !rst) begin
                wr_valid = 1'b1;
                wr_rs    = rs;
                wr_data  = data;
                w.rs     = rs;
                w.data   = data;
                w.acc    = cyc + 1;
                exp_q.push_back(w);
                n_accepts++;
                done = 1;
            end else begin
                if (scramble) begin
                    wr_valid = 1'($urandom);
                    wr_rs    = 1'($urandom);
                    wr_data  = 8'($urandom);
                end else begin
                    wr_valid = 1'b1;
                    wr_rs    = rs;
                    wr_data  = data;
                end
                waited++;
                if (waited > 100) begin
                    checkOutput("accept_timeout", 32'd0, 32'd1);
                    done = 1;
                end
            end
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(negedge clk);
            wr_valid = 1'b0;
            wr_rs    = 1'($urandom);
            wr_data  = 8'($urandom);
        end
    endtask

    initial begin
        bit seen;
        rst      = 1'b1;
        wr_valid = 1'b1;
        wr_rs    = 1'b0;
        wr_data  = 8'h38;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        applyStimulus(1'b0, 8'h38, 1'b0);
        applyStimulus(1'b0, 8'h01, 1'b1);
        applyStimulus(1'b1, 8'h01, 1'b1);
        applyStimulus(1'b0, 8'h02, 1'b1);
        applyStimulus(1'b0, 8'h03, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b1, 8'h02, 1'b1);
        applyStimulus(1'b1, 8'h41, 1'b0);
        applyStimulus(1'b1, 8'h42, 1'b0);
        applyStimulus(1'b1, 8'h43, 1'b0);
        idleCycles(4);

        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom),
                          1'b1);
            if ($urandom_range(0, 2) == 0) idleCycles($urandom_range(1, 8));
        end

        applyStimulus(1'b0, 8'h38, 1'b1);
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            wr_valid = 1'b0;
            if (lcd_e) seen = 1;
        end
        if (!seen) checkOutput("e_wait_timeout", 32'd0, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(1'b1, 8'h55, 1'b1);
        idleCycles(1);
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            wr_valid = 1'b0;
            if (wr_ready) seen = 1;
        end
        if (!seen) checkOutput("final_ready_timeout", 32'd0, 32'd1);
        idleCycles(3);

        checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
        checkOutput("accepts_seen", 32'(n_popped), 32'(n_accepts));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
